// File: rtl/mmm_pkg.sv
// Shared fetch-path types: XLEN/ILEN, branch prediction record, and the
// entry formats held by the fetch queue and its in-flight request FIFO.
package mmm_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    prediction_t     pred;
  } fq_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    prediction_t     pred;
  } fq_meta_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised-type FIFO with synchronous clear; head is read combinationally
// from storage. Storage resets to zero so the head reads zero out of reset.
module fetch_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i & ~full & ~clr_i;
  assign do_pop  = pop_i & ~empty & ~clr_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Explicit wrap keeps non-power-of-two depths (meta FIFO) correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full && !clr_i));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: credit-limited i-cache requests, in-order response
// buffering toward decode, flush with in-flight response dropping.
// Optional FETCH_QUEUE_BYPASS_EN: responses reaching an empty queue issue same cycle.
//
// Handshakes are valid/ready: a transfer happens on a cycle where both are high;
// valid never depends on ready of the same channel.
module fetch_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [XLEN-1:0]                      pc_i,
  input  logic                                 pc_valid_i,
  input  prediction_t                          pred_i,
  output logic                                 fetch_ready_o,
  output logic [XLEN-1:0]                      addr_o,
  output logic                                 addr_valid_o,
  input  logic                                 addr_ready_i,
  input  logic [ILEN-1:0]                      data_i,
  input  logic                                 data_valid_i,
  output logic                                 data_ready_o,
  output logic                                 issue_valid_o,
  input  logic                                 issue_ready_i,
  output logic [ILEN-1:0]                      instruction_o,
  output logic [XLEN-1:0]                      pc_o,
  output prediction_t                          pred_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_drop_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0]           dbg_count_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          ready_q;

  logic [CW-1:0] q_count;
  logic [OW-1:0] meta_count;
  logic [SW-1:0] occupancy;
  logic          q_empty, q_push, q_pop;
  logic          credit_ok, req_fire, resp_fire, resp_keep, bypass;
  fq_meta_t      meta_in, meta_head;
  fq_entry_t     q_in, q_head, head;

  // Queue space is reserved when a request is sent, so responses always fit.
  assign occupancy = SW'(outstanding_q) + SW'(q_count);
  assign credit_ok = (outstanding_q < OW'(MAX_OUTSTANDING)) && (occupancy < SW'(DEPTH));

  assign addr_o        = pc_i;
  assign addr_valid_o  = pc_valid_i & credit_ok & ~flush_i;
  assign fetch_ready_o = addr_ready_i & credit_ok & ~flush_i;
  assign req_fire      = addr_valid_o & addr_ready_i;

  assign data_ready_o = ready_q;
  assign resp_fire    = data_valid_i & ready_q;
  assign resp_keep    = resp_fire & ~flush_i & (drop_cnt_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_keep & q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_empty       = (q_count == '0);
  assign issue_valid_o = (~q_empty | bypass) & ~flush_i;
  assign q_pop         = ~q_empty & issue_valid_o & issue_ready_i;
  assign q_push        = resp_keep & ~(bypass & issue_ready_i);

  assign meta_in = '{pc: pc_i, pred: pred_i};
  assign q_in    = '{instr: data_i, pc: meta_head.pc, pred: meta_head.pred};
  assign head    = bypass ? q_in : q_head;

  assign instruction_o = head.instr;
  assign pc_o          = head.pc;
  assign pred_o        = head.pred;

  assign dbg_outstanding_o = outstanding_q;
  assign dbg_drop_cnt_o    = drop_cnt_q;
  assign dbg_count_o       = q_count;

  fetch_fifo #(.T(fq_meta_t), .DEPTH(MAX_OUTSTANDING)) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (req_fire),
    .data_i  (meta_in),
    .pop_i   (resp_keep),
    .data_o  (meta_head),
    .count_o (meta_count)
  );

  fetch_fifo #(.T(fq_entry_t), .DEPTH(DEPTH)) u_instr_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_count)
  );

  // On flush, every request still unanswered after this cycle must be dropped.
  always_comb begin
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);
    drop_cnt_d    = drop_cnt_q;
    if (flush_i)                             drop_cnt_d = outstanding_q - OW'(resp_fire);
    else if (resp_fire && drop_cnt_q != '0)  drop_cnt_d = drop_cnt_q - OW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      ready_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      ready_q       <= 1'b1;
    end
  end

  a_meta_tracks_live: assert property (@(posedge clk_i) disable iff (rst_i)
    meta_count == outstanding_q - drop_cnt_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an i-cache responder model and an
// expected-entry scoreboard; honours FETCH_QUEUE_BYPASS_EN when defined.
module tb_fetch_queue;
  import mmm_pkg::*;

  localparam int EW = $bits(fq_entry_t);

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_valid_i = 1'b0;
  prediction_t     pred_i = '0;
  logic            fetch_ready_o;
  logic [XLEN-1:0] addr_o;
  logic            addr_valid_o;
  logic            addr_ready_i = 1'b0;
  logic [ILEN-1:0] data_i = '0;
  logic            data_valid_i = 1'b0;
  logic            data_ready_o;
  logic            issue_valid_o;
  logic            issue_ready_i = 1'b0;
  logic [ILEN-1:0] instruction_o;
  logic [XLEN-1:0] pc_o;
  prediction_t     pred_o;
  logic [1:0]      dbg_outstanding_o, dbg_drop_cnt_o;
  logic [2:0]      dbg_count_o;

  fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .pc_i(pc_i),
    .pc_valid_i(pc_valid_i), .pred_i(pred_i), .fetch_ready_o(fetch_ready_o),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .pred_o(pred_o),
    .dbg_outstanding_o(dbg_outstanding_o), .dbg_drop_cnt_o(dbg_drop_cnt_o),
    .dbg_count_o(dbg_count_o)
  );

  always #5 clk_i = ~clk_i;

  int              vectors = 0;
  int              errors  = 0;
  int              issued  = 0;
  int              model_drop = 0;
  int              base;
  bit              resp_en = 1'b0;
  bit              offer_en = 1'b0;
  logic [XLEN-1:0] last_pc = '0;
  logic [XLEN-1:0] pc_list[$];
  logic [XLEN-1:0] pending[$];
  logic [EW-1:0]   exp_q[$];

  function automatic prediction_t make_pred(input logic [XLEN-1:0] pc);
    make_pred = '{taken: pc[2], target: pc + 32'h40};
  endfunction

  function automatic fq_entry_t make_entry(input logic [XLEN-1:0] pc);
    make_entry = '{instr: pc ^ 32'h0000_0013, pc: pc, pred: make_pred(pc)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle checks and model update, sampled at the falling edge.
  task automatic observe();
    fq_entry_t e;
    bit        credit, byp;
    logic [XLEN-1:0] p;
    chk("outstanding", 128'(dbg_outstanding_o), 128'(pending.size()));
    chk("count", 128'(dbg_count_o), 128'(exp_q.size()));
    chk("drop_cnt", 128'(dbg_drop_cnt_o), 128'(model_drop));
    credit = (pending.size() < 2) && (pending.size() + exp_q.size() < 4);
    chk("fetch_ready", 128'(fetch_ready_o), 128'(addr_ready_i && credit && !flush_i));
    chk("addr_valid", 128'(addr_valid_o), 128'(pc_valid_i && credit && !flush_i));
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (exp_q.size() == 0) && (model_drop == 0) && data_valid_i && data_ready_o && !flush_i;
`else
    byp = 1'b0;
`endif
    chk("issue_valid", 128'(issue_valid_o), 128'(((exp_q.size() > 0) || byp) && !flush_i));
    if (data_valid_i && data_ready_o) begin
      p = pending.pop_front();
      if (flush_i) ;
      else if (model_drop > 0) model_drop--;
      else exp_q.push_back(make_entry(p));
    end
    if (flush_i) begin
      exp_q.delete();
      model_drop = pending.size();
    end
    if (addr_valid_o && addr_ready_i) begin
      chk("addr", 128'(addr_o), 128'(pc_list[0]));
      pending.push_back(pc_list.pop_front());
    end
    if (issue_valid_o && issue_ready_i) begin
      if (exp_q.size() == 0) chk("issue_unexpected", 128'(1), 128'(0));
      else begin
        e = exp_q.pop_front();
        chk("issue_pc", 128'(pc_o), 128'(e.pc));
        chk("issue_instr", 128'(instruction_o), 128'(e.instr));
        chk("issue_pred", 128'(pred_o), 128'(e.pred));
        issued++;
        last_pc = pc_o;
      end
    end
  endtask

  task automatic drive();
    pc_valid_i   = offer_en && (pc_list.size() > 0);
    pc_i         = pc_valid_i ? pc_list[0] : '0;
    pred_i       = make_pred(pc_i);
    data_valid_i = resp_en && (pending.size() > 0);
    data_i       = data_valid_i ? make_entry(pending[0]).instr : '0;
    @(negedge clk_i);
    observe();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (n < bound && !(pc_list.size() == 0 && pending.size() == 0 && exp_q.size() == 0)) begin
      drive();
      n++;
    end
    chk(tag, 128'(n < bound), 128'(1));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_issue_valid", 128'(issue_valid_o), 128'(0));
    chk("rst_addr_valid", 128'(addr_valid_o), 128'(0));
    chk("rst_fetch_ready", 128'(fetch_ready_o), 128'(0));
    chk("rst_data_ready", 128'(data_ready_o), 128'(0));
    chk("rst_head", 128'({instruction_o, pc_o, pred_o}), 128'(0));
    chk("rst_counters", 128'({dbg_outstanding_o, dbg_drop_cnt_o, dbg_count_o}), 128'(0));
    @(posedge clk_i); #1;
    addr_ready_i = 1'b1;
    rst_i = 1'b0;
    drive();
    chk("data_ready_up", 128'(data_ready_o), 128'(1));

    // Streaming, latency 1
    offer_en = 1'b1; resp_en = 1'b1; issue_ready_i = 1'b1;
    base = issued;
    for (int i = 0; i < 4; i++) pc_list.push_back(32'h100 + 32'(4 * i));
    drain("stream_drain", 40);
    chk("stream_issued", 128'(issued - base), 128'(4));
    chk("stream_last", 128'(last_pc), 128'(32'h10C));

    // Backpressure: 8 PCs into a 4-entry queue
    issue_ready_i = 1'b0;
    base = issued;
    for (int i = 0; i < 8; i++) pc_list.push_back(32'h300 + 32'(4 * i));
    for (int i = 0; i < 20; i++) drive();
    chk("bp_full", 128'(dbg_count_o), 128'(4));
    chk("bp_waiting", 128'(pc_list.size()), 128'(4));
    chk("bp_fetch_ready", 128'(fetch_ready_o), 128'(0));
    issue_ready_i = 1'b1;
    drain("bp_drain", 80);
    chk("bp_issued", 128'(issue_ready_i ? issued - base : 0), 128'(8));

    // Flush with two requests outstanding
    resp_en = 1'b0;
    pc_list.push_back(32'h400); pc_list.push_back(32'h404);
    for (int i = 0; i < 10 && pending.size() < 2; i++) drive();
    chk("fl_outstanding", 128'(dbg_outstanding_o), 128'(2));
    base = issued;
    flush_i = 1'b1; drive(); flush_i = 1'b0;
    resp_en = 1'b1;
    for (int i = 0; i < 4; i++) drive();
    chk("fl_dropped", 128'(issued - base), 128'(0));
    pc_list.push_back(32'h200);
    drain("fl_drain", 20);
    chk("fl_first_new", 128'(last_pc), 128'(32'h200));
    chk("fl_issued", 128'(issued - base), 128'(1));

    // Flush coinciding with a response: one more response must be dropped
    resp_en = 1'b0;
    pc_list.push_back(32'h500); pc_list.push_back(32'h504);
    for (int i = 0; i < 10 && pending.size() < 2; i++) drive();
    base = issued;
    resp_en = 1'b1; flush_i = 1'b1; drive(); flush_i = 1'b0;
    chk("flr_drop_cnt", 128'(dbg_drop_cnt_o), 128'(1));
    drain("flr_drain", 20);
    chk("flr_none", 128'(issued - base), 128'(0));
    pc_list.push_back(32'h600);
    drain("flr_drain2", 20);
    chk("flr_after", 128'(last_pc), 128'(32'h600));
    chk("flr_issued", 128'(issued - base), 128'(1));

    // Empty-queue response (same-cycle issue only with bypass enabled)
    base = issued;
    pc_list.push_back(32'h0);
    drain("byp_drain", 20);
    chk("byp_issued", 128'(issued - base), 128'(1));
    chk("byp_pc", 128'(last_pc), 128'(0));

    // Async reset with three entries queued
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) pc_list.push_back(32'h700 + 32'(4 * i));
    for (int i = 0; i < 20 && !(exp_q.size() == 3 && pending.size() == 0); i++) drive();
    chk("rm_queued", 128'(dbg_count_o), 128'(3));
    #2 rst_i = 1'b1;
    #1;
    chk("rm_issue_valid", 128'(issue_valid_o), 128'(0));
    chk("rm_counters", 128'({dbg_outstanding_o, dbg_drop_cnt_o, dbg_count_o}), 128'(0));
    chk("rm_data_ready", 128'(data_ready_o), 128'(0));
    pc_list.delete(); pending.delete(); exp_q.delete(); model_drop = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    issue_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) drive();
    pc_list.push_back(32'h800);
    drain("post_rst_drain", 20);
    chk("post_rst_pc", 128'(last_pc), 128'(32'h800));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
